// File: rtl/ddr_pkg.sv
// Shared DDR client widths, reader state encoding and burst sizing helper.
package ddr_pkg;

    localparam int DDR_ADDR_W  = 29;
    localparam int DDR_DATA_W  = 64;
    localparam int DDR_BURST_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_DRAIN
    } rd_state_e;

    // Next burst length: the smaller of the words still owed and the burst cap.
    function automatic logic [15:0] min_burst(input logic [15:0] remaining,
                                              input int unsigned max_burst);
        if (remaining > 16'(max_burst)) begin
            return 16'(max_burst);
        end
        return remaining;
    endfunction

endpackage

// File: rtl/ddr_if.sv
// One DDR arbiter input port: request/address side driven by the client,
// busy and read-return side driven by the arbiter.
interface ddr_if;
    import ddr_pkg::*;

    logic [DDR_ADDR_W-1:0]  addr;
    logic [DDR_DATA_W-1:0]  wdata;
    logic                   read;
    logic                   write;
    logic [DDR_BURST_W-1:0] burstcnt;
    logic [7:0]             byteenable;
    logic                   acquire;
    logic                   busy;
    logic                   rdata_ready;
    logic [DDR_DATA_W-1:0]  rdata;

    modport to_host (
        output addr, wdata, read, write, burstcnt, byteenable, acquire,
        input  busy, rdata_ready, rdata
    );

    modport to_arb (
        input  addr, wdata, read, write, burstcnt, byteenable, acquire,
        output busy, rdata_ready, rdata
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: head word is presented whenever non-empty.
// Pop on empty and push on full are ignored; flush empties it in one edge.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Qualify requests against the current occupancy.
    always_comb begin
        do_push = push && (count_q != CW'(DEPTH));
        do_pop  = pop && (count_q != '0);
    end

    // Pointer and occupancy tracking; flush behaves like reset.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, written only; no reset needed on data.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/ddr_stream_reader.sv
// Streams a run of 64-bit words out of DDR as a sequence of read bursts and
// presents them through a show-ahead FIFO. A burst is only requested once the
// FIFO has room for every beat of it, so the return path never back-pressures.
module ddr_stream_reader
    import ddr_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    ddr_if.to_host                ddr,
    input  logic                  start,
    input  logic [DDR_ADDR_W-1:0] base_addr,
    input  logic [15:0]           length,
    input  logic                  abort,
    output logic [DDR_DATA_W-1:0] data,
    output logic                  valid,
    input  logic                  pop,
    output logic                  active,
    output logic                  done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e              state_q;
    logic [DDR_ADDR_W-1:0]  addr_q;
    logic [DDR_ADDR_W-1:0]  rd_addr_q;
    logic [15:0]            remaining_q;
    logic [DDR_BURST_W-1:0] burstcnt_q;
    logic [DDR_BURST_W-1:0] beats_q;
    logic                   read_q;
    logic                   done_q;

    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          free_slots;
    logic [15:0]            burst_n;
    logic                   accept;
    logic                   last_beat;
    logic                   push;
    logic                   flush;

    // Burst sizing, handshake decode and FIFO control derived from current state.
    always_comb begin
        burst_n    = min_burst(remaining_q, MAX_BURST);
        free_slots = CW'(FIFO_DEPTH) - fifo_count;
        accept     = (state_q == ST_REQ) && read_q && !ddr.busy;
        push       = (state_q == ST_DATA) && ddr.rdata_ready;
        last_beat  = ((state_q == ST_DATA) || (state_q == ST_DRAIN))
                     && ddr.rdata_ready && (beats_q == DDR_BURST_W'(1));
        // Every abort path empties the FIFO on the edge that enters IDLE.
        flush      = ((state_q == ST_REQ) && abort && !accept)
                     || ((state_q == ST_DATA) && abort && last_beat)
                     || ((state_q == ST_DRAIN) && last_beat);
    end

    // Stream control FSM with registered DDR request outputs and done pulse.
    // An abort landing on the accept edge still owes the whole burst, so it
    // goes through DRAIN rather than straight to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            burstcnt_q  <= '0;
            beats_q     <= '0;
            read_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            addr_q      <= base_addr;
                            remaining_q <= length;
                            state_q     <= ST_REQ;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (accept) begin
                        read_q      <= 1'b0;
                        addr_q      <= addr_q + DDR_ADDR_W'(burstcnt_q);
                        remaining_q <= remaining_q - 16'(burstcnt_q);
                        beats_q     <= burstcnt_q;
                        state_q     <= abort ? ST_DRAIN : ST_DATA;
                    end else if (abort) begin
                        read_q  <= 1'b0;
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else if (!read_q && (32'(free_slots) >= 32'(burst_n))) begin
                        read_q     <= 1'b1;
                        burstcnt_q <= DDR_BURST_W'(burst_n);
                        rd_addr_q  <= addr_q;
                    end
                end
                ST_DATA: begin
                    if (ddr.rdata_ready) begin
                        beats_q <= beats_q - DDR_BURST_W'(1);
                    end
                    if (last_beat) begin
                        if (abort || (remaining_q == '0)) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_REQ;
                        end
                    end else if (abort) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ddr.rdata_ready) begin
                        beats_q <= beats_q - DDR_BURST_W'(1);
                    end
                    if (last_beat) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DDR_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .wdata (ddr.rdata),
        .pop   (pop),
        .rdata (data),
        .valid (valid),
        .count (fifo_count)
    );

    assign ddr.addr       = rd_addr_q;
    assign ddr.read       = read_q;
    assign ddr.burstcnt   = burstcnt_q;
    assign ddr.acquire    = (state_q != ST_IDLE);
    assign ddr.write      = 1'b0;
    assign ddr.wdata      = '0;
    assign ddr.byteenable = '1;

    assign active = (state_q != ST_IDLE);
    assign done   = done_q;

endmodule

// File: tb/tb_ddr_stream_reader.sv
// Bench for ddr_stream_reader: a single process plays the DDR arbiter and the
// consumer, predicting bursts, words and done pulses from the stream rules.
module tb_ddr_stream_reader;
    import ddr_pkg::*;

    localparam int MB    = 8;
    localparam int DEPTH = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  abort;
    logic                  pop;
    logic                  valid;
    logic                  active;
    logic                  done;
    logic [DDR_ADDR_W-1:0] base_addr;
    logic [15:0]           length;
    logic [DDR_DATA_W-1:0] data;

    ddr_if ddr ();

    ddr_stream_reader #(
        .FIFO_DEPTH (DEPTH),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ddr       (ddr),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .data      (data),
        .valid     (valid),
        .pop       (pop),
        .active    (active),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int  busy_mode, busy_left, pop_mode, pop_budget;
    bit  gap_rand, beat_hold, draining, drain_end, hold_armed;
    int  read_cycles, accept_at;
    logic [28:0] hold_addr;
    logic [7:0]  hold_cnt;
    int  held, beats_seen, stream_len, done_cnt, acc_total;

    logic [63:0] exp_q[$];
    logic [28:0] exp_baddr_q[$];
    logic [7:0]  exp_bcnt_q[$];
    logic [28:0] beat_addr_q[$];

    // Contents of DDR as seen by the bench.
    function automatic logic [63:0] mem_word(input logic [28:0] a);
        return {3'b101, a, 32'hC0DE_0000 ^ {3'b000, a}};
    endfunction

    // One clock: drive arbiter/consumer side, check outputs, advance, observe.
    task automatic step();
        logic [28:0] a;
        logic [28:0] eb;
        logic [7:0]  en;
        bit          pushed;
        bit          final_beat;
        pushed     = 1'b0;
        final_beat = 1'b0;

        if (busy_mode == 2) begin
            if (hold_armed && ddr.read) begin
                read_cycles++;
                if (read_cycles == 1) begin
                    hold_addr = ddr.addr;
                    hold_cnt  = ddr.burstcnt;
                end else begin
                    checks++;
                    if (ddr.addr !== hold_addr || ddr.burstcnt !== hold_cnt) begin
                        errors++;
                        $display("FAIL busy_hold_stable: got addr=%h cnt=%0d expected addr=%h cnt=%0d",
                                 ddr.addr, ddr.burstcnt, hold_addr, hold_cnt);
                    end
                end
            end else if (hold_armed && read_cycles > 0) begin
                checks++;
                errors++;
                $display("FAIL busy_hold_read: got read=%b expected 1", ddr.read);
            end
            ddr.busy = hold_armed && ddr.read && (busy_left > 0);
            if (ddr.busy) busy_left--;
        end else if (busy_mode == 1) begin
            ddr.busy = ($urandom_range(0, 2) == 0);
        end else begin
            ddr.busy = 1'b0;
        end

        ddr.rdata_ready = 1'b0;
        ddr.rdata       = '0;
        if (!beat_hold && beat_addr_q.size() > 0 && (!gap_rand || $urandom_range(0, 3) != 0)) begin
            a = beat_addr_q.pop_front();
            ddr.rdata_ready = 1'b1;
            ddr.rdata       = mem_word(a);
            if (!draining) begin
                pushed = 1'b1;
                beats_seen++;
                if (beats_seen == stream_len) final_beat = 1'b1;
            end else if (beat_addr_q.size() == 0) begin
                drain_end = 1'b1;
            end
        end

        if (ddr.read && !ddr.busy) begin
            acc_total++;
            checks++;
            if (exp_baddr_q.size() == 0) begin
                errors++;
                $display("FAIL burst_unexpected: got addr=%h cnt=%0d expected no burst",
                         ddr.addr, ddr.burstcnt);
            end else begin
                eb = exp_baddr_q.pop_front();
                en = exp_bcnt_q.pop_front();
                if (ddr.addr !== eb || ddr.burstcnt !== en) begin
                    errors++;
                    $display("FAIL burst: got addr=%h cnt=%0d expected addr=%h cnt=%0d",
                             ddr.addr, ddr.burstcnt, eb, en);
                end
            end
            checks++;
            if (held + int'(pushed) + beat_addr_q.size() + int'(ddr.burstcnt) > DEPTH) begin
                errors++;
                $display("FAIL fifo_room: got occupancy %0d plus burst %0d expected at most %0d",
                         held + beat_addr_q.size(), ddr.burstcnt, DEPTH);
            end
            for (int k = 0; k < int'(ddr.burstcnt); k++) begin
                beat_addr_q.push_back(ddr.addr + 29'(k));
            end
            if (hold_armed) begin
                accept_at  = read_cycles;
                hold_armed = 1'b0;
            end
        end

        case (pop_mode)
            1:       pop = 1'b1;
            2:       pop = ($urandom_range(0, 1) == 1);
            3:       pop = (pop_budget > 0);
            default: pop = 1'b0;
        endcase
        checks++;
        if (valid !== (held > 0)) begin
            errors++;
            $display("FAIL valid: got %b expected %b", valid, (held > 0));
        end
        if (held > 0) begin
            checks++;
            if (data !== exp_q[0]) begin
                errors++;
                $display("FAIL data: got %h expected %h", data, exp_q[0]);
            end
        end
        if (pop && held > 0) begin
            void'(exp_q.pop_front());
            held--;
            if (pop_mode == 3) pop_budget--;
        end
        if (pushed) held++;

        @(posedge clk);
        @(negedge clk);

        if (done === 1'b1) done_cnt++;
        if (final_beat) begin
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL done_last_beat: got %b expected 1", done);
            end
        end
        if (drain_end) begin
            held = 0;
            exp_q.delete();
            draining  = 1'b0;
            drain_end = 1'b0;
        end
    endtask

    // Predict bursts and words for a stream, then issue start.
    task automatic arm_stream(input logic [28:0] b, input int len);
        logic [28:0] a;
        int rem;
        int n;
        exp_q.delete();
        exp_baddr_q.delete();
        exp_bcnt_q.delete();
        beats_seen = 0;
        stream_len = len;
        done_cnt   = 0;
        acc_total  = 0;
        a   = b;
        rem = len;
        while (rem > 0) begin
            n = (rem > MB) ? MB : rem;
            exp_baddr_q.push_back(a);
            exp_bcnt_q.push_back(8'(n));
            a   = a + 29'(n);
            rem = rem - n;
        end
        for (int i = 0; i < len; i++) exp_q.push_back(mem_word(b + 29'(i)));
        base_addr = b;
        length    = 16'(len);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic finish_stream(input int budget);
        int cyc;
        cyc = 0;
        while ((done_cnt == 0 || held > 0) && cyc < budget) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc >= budget) begin
            errors++;
            $display("FAIL stream_timeout: got %0d cycles expected under %0d", cyc, budget);
        end
        repeat (3) step();
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL done_count: got %0d expected 1", done_cnt);
        end
        checks++;
        if (exp_baddr_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_leftover: got %0d bursts %0d words expected 0 0",
                     exp_baddr_q.size(), exp_q.size());
        end
    endtask

    task automatic run_stream(input logic [28:0] b, input int len, input int budget);
        arm_stream(b, len);
        finish_stream(budget);
    endtask

    task automatic wait_accept(input int target);
        int cyc;
        cyc = 0;
        while (acc_total < target && cyc < 50) begin
            step();
            cyc++;
        end
        checks++;
        if (acc_total < target) begin
            errors++;
            $display("FAIL accept_timeout: got %0d bursts expected %0d", acc_total, target);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (ddr.read !== 1'b0 || ddr.acquire !== 1'b0 || ddr.burstcnt !== 8'd0 ||
            ddr.addr !== 29'd0 || valid !== 1'b0 || active !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s: got read=%b acq=%b cnt=%0d addr=%h valid=%b active=%b done=%b expected all 0",
                     tag, ddr.read, ddr.acquire, ddr.burstcnt, ddr.addr, valid, active, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        checks++;
        if (ddr.write !== 1'b0 || ddr.wdata !== 64'd0 || ddr.byteenable !== 8'hFF) begin
            errors++;
            $display("FAIL write_side: got write=%b wdata=%h be=%h expected 0 0 ff",
                     ddr.write, ddr.wdata, ddr.byteenable);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_stream();
        busy_mode = 0; pop_mode = 1; gap_rand = 1'b0;
        run_stream(29'h100, 20, 400);
        checks++;
        if (acc_total !== 3) begin
            errors++;
            $display("FAIL basic_burst_count: got %0d expected 3", acc_total);
        end
    endtask

    task automatic test_zero_length();
        arm_stream(29'h55, 0);
        checks++;
        if (done !== 1'b1 || ddr.acquire !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_done: got done=%b acq=%b active=%b expected 1 0 0",
                     done, ddr.acquire, active);
        end
        repeat (4) begin
            step();
            checks++;
            if (ddr.acquire !== 1'b0 || ddr.read !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL zero_len_quiet: got acq=%b read=%b done=%b expected 0 0 0",
                         ddr.acquire, ddr.read, done);
            end
        end
    endtask

    task automatic test_busy_hold();
        busy_mode = 2; busy_left = 5; hold_armed = 1'b1; read_cycles = 0; accept_at = -1;
        pop_mode = 1;
        run_stream(29'h1234, 8, 200);
        checks++;
        if (accept_at !== 6) begin
            errors++;
            $display("FAIL busy_accept_cycle: got %0d expected 6", accept_at);
        end
        busy_mode = 0; hold_armed = 1'b0;
    endtask

    task automatic test_backpressure();
        busy_mode = 0; pop_mode = 0;
        arm_stream(29'h4000, 40);
        repeat (60) step();
        checks++;
        if (acc_total !== 2 || valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_two_bursts: got bursts=%0d valid=%b expected 2 1", acc_total, valid);
        end
        pop_mode = 3; pop_budget = 7;
        repeat (12) step();
        checks++;
        if (acc_total !== 2) begin
            errors++;
            $display("FAIL bp_seven_pops: got bursts=%0d expected 2", acc_total);
        end
        pop_budget = 1;
        repeat (12) step();
        checks++;
        if (acc_total !== 3) begin
            errors++;
            $display("FAIL bp_eight_pops: got bursts=%0d expected 3", acc_total);
        end
        pop_mode = 1;
        finish_stream(400);
    endtask

    task automatic test_abort_drain();
        busy_mode = 0; pop_mode = 0; beat_hold = 1'b1;
        arm_stream(29'h300, 16);
        wait_accept(1);
        beat_hold = 1'b0;
        repeat (3) step();
        beat_hold = 1'b1;
        abort     = 1'b1;
        draining  = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (active !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_enter_drain: got active=%b done=%b expected 1 0", active, done);
        end
        beat_hold = 1'b0;
        for (int i = 0; i < 20 && done_cnt == 0; i++) step();
        checks++;
        if (done_cnt !== 1 || beat_addr_q.size() != 0) begin
            errors++;
            $display("FAIL abort_drain_done: got done=%0d beats_left=%0d expected 1 0",
                     done_cnt, beat_addr_q.size());
        end
        step();
        checks++;
        if (valid !== 1'b0 || active !== 1'b0 || ddr.acquire !== 1'b0) begin
            errors++;
            $display("FAIL abort_flushed: got valid=%b active=%b acq=%b expected 0 0 0",
                     valid, active, ddr.acquire);
        end
        exp_baddr_q.delete();
        exp_bcnt_q.delete();
        pop_mode = 1;
        run_stream(29'h200, 12, 300);
    endtask

    task automatic test_reset_midburst();
        busy_mode = 0; pop_mode = 0; beat_hold = 1'b1;
        arm_stream(29'h500, 16);
        wait_accept(1);
        beat_hold = 1'b0;
        repeat (2) step();
        beat_hold = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        held = 0;
        exp_q.delete();
        beat_addr_q.delete();
        exp_baddr_q.delete();
        exp_bcnt_q.delete();
        check_idle_outputs("reset_midburst");
        for (int i = 0; i < 4; i++) begin
            ddr.rdata_ready = 1'b1;
            ddr.rdata       = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (valid !== 1'b0 || ddr.acquire !== 1'b0 || active !== 1'b0) begin
                errors++;
                $display("FAIL stray_beat: got valid=%b acq=%b active=%b expected 0 0 0",
                         valid, ddr.acquire, active);
            end
        end
        ddr.rdata_ready = 1'b0;
        beat_hold = 1'b0;
    endtask

    task automatic test_random_streams();
        logic [28:0] b;
        busy_mode = 1; pop_mode = 2; gap_rand = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = (i == 0) ? 29'h1FFF_FFFA : 29'($urandom);
            run_stream(b, int'($urandom_range(1, 40)), 3000);
        end
        busy_mode = 0; pop_mode = 0; gap_rand = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; pop = 1'b0;
        base_addr = '0; length = '0;
        ddr.busy = 1'b0; ddr.rdata_ready = 1'b0; ddr.rdata = '0;
        busy_mode = 0; busy_left = 0; pop_mode = 0; pop_budget = 0;
        gap_rand = 1'b0; beat_hold = 1'b0; draining = 1'b0; drain_end = 1'b0;
        hold_armed = 1'b0; read_cycles = 0; accept_at = -1;
        held = 0; beats_seen = 0; stream_len = 0; done_cnt = 0; acc_total = 0;

        test_reset();
        test_basic_stream();
        test_zero_length();
        test_busy_hold();
        test_backpressure();
        test_abort_drain();
        test_reset_midburst();
        test_random_streams();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
